// File: rtl/pic_irq_resolver.sv
// PIC interrupt front end: IRR capture (edge/level), masking, rotating
// fully-nested priority resolution, and ISR bookkeeping for INTA/EOI strobes.
module pic_irq_resolver (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       LTIM,
  input  logic [7:0] Mask,
  input  logic       inta_p1,
  input  logic       inta_p2,
  input  logic       eoi,
  input  logic       seoi,
  input  logic [2:0] lvl,
  input  logic       ar,
  input  logic       aeoi,
  output logic       intr,
  output logic [2:0] Y,
  output logic       spur,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  logic [7:0] ir_d;
  logic [2:0] lp;

  // Returns {found, level} of the highest-priority set bit, scanning from lp+1.
  function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'd1 + 3'(k);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // 0 is the highest priority under the current pointer.
  function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] p);
    return l - p - 3'd1;
  endfunction

  logic       cand_vld, top_vld, int_next, p2_clr;
  logic [2:0] cand, top, lp_next;
  logic [7:0] set_isr, clr_isr, irr_next;

  always_comb begin
    {cand_vld, cand} = pick(irr & ~Mask, lp);
    {top_vld, top}   = pick(isr, lp);
    int_next = cand_vld && (!top_vld || (rank(cand, lp) < rank(top, lp)));

    set_isr = (inta_p1 && cand_vld) ? (8'd1 << cand) : 8'd0;
    p2_clr  = inta_p2 && aeoi && !spur;
    clr_isr = p2_clr ? (8'd1 << Y) : 8'd0;
    lp_next = lp;
    if (ar && p2_clr) lp_next = Y;
    // Specific EOI overrides a concurrent non-specific EOI.
    if (seoi) begin
      clr_isr = clr_isr | (8'd1 << lvl);
      if (ar) lp_next = lvl;
    end else if (eoi && top_vld) begin
      clr_isr = clr_isr | (8'd1 << top);
      if (ar) lp_next = top;
    end

    irr_next = LTIM ? ir : ((irr & ~set_isr) | (ir & ~ir_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irr  <= 8'd0;
      isr  <= 8'd0;
      intr <= 1'b0;
      Y    <= 3'd7;
      spur <= 1'b0;
      ir_d <= 8'd0;
      lp   <= 3'd7;
    end else begin
      ir_d <= ir;
      irr  <= irr_next;
      isr  <= (isr & ~clr_isr) | set_isr;
      lp   <= lp_next;
      intr <= inta_p1 ? 1'b0 : int_next;
      if (inta_p1) begin
        Y    <= cand_vld ? cand : 3'd7;
        spur <= !cand_vld;
      end
    end
  end

endmodule
